// File: rtl/receiver.sv
// rtl/receiver.sv - UART receiver: 1 start, 7 data LSB-first, odd parity, 1 stop; optional macro RX_MAJORITY_EN enables 3-sample majority vote
module receiver #(
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic       rx_en,
    input  logic       rx,
    output logic [6:0] data_out,
    output logic       valid,
    output logic       parity_err,
    output logic       frame_err,
    output logic       busy
);

    localparam int CW = $clog2(OVERSAMPLE);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] DATA  = 2'd2;
    localparam logic [1:0] STOP  = 2'd3;

    localparam logic [CW-1:0] LAST = CW'(OVERSAMPLE - 1);
`ifdef RX_MAJORITY_EN
    localparam logic [CW-1:0] VOTE_A = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] VOTE_B = CW'(OVERSAMPLE / 2);
    localparam logic [CW-1:0] DEC    = CW'(OVERSAMPLE / 2 + 1);
`else
    localparam logic [CW-1:0] DEC    = CW'(OVERSAMPLE / 2);
`endif

    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic [2:0]    idx;
    logic [7:0]    shift;
    logic          armed;
    logic          rx_m;
    logic          rx_s;
    logic          sample;

    // two-flop synchronizer for the asynchronous serial line, idles high
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= rx;
            rx_s <= rx_m;
        end
    end

`ifdef RX_MAJORITY_EN
    logic vote_a;
    logic vote_b;

    // capture the two samples preceding the decision tick for the vote
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            vote_a <= 1'b1;
            vote_b <= 1'b1;
        end else if (rx_en) begin
            if (cnt == VOTE_A) vote_a <= rx_s;
            if (cnt == VOTE_B) vote_b <= rx_s;
        end
    end

    assign sample = (vote_a & vote_b) | (vote_a & rx_s) | (vote_b & rx_s);
`else
    assign sample = rx_s;
`endif

    assign busy = (state != IDLE);

    // frame state machine: start detect, mid-bit sampling, result publish at mid-stop
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state      <= IDLE;
            cnt        <= '0;
            idx        <= 3'd0;
            shift      <= 8'd0;
            armed      <= 1'b0;
            data_out   <= 7'd0;
            valid      <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            valid <= 1'b0;
            if (rx_en) begin
                case (state)
                    IDLE: begin
                        if (rx_s) begin
                            armed <= 1'b1;
                        end else if (armed) begin
                            state <= START;
                            cnt   <= '0;
                            armed <= 1'b0;
                        end
                    end
                    START: begin
                        if (cnt == DEC && sample) begin
                            state <= IDLE;
                            cnt   <= '0;
                        end else if (cnt == LAST) begin
                            state <= DATA;
                            cnt   <= '0;
                            idx   <= 3'd0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    DATA: begin
                        if (cnt == DEC) shift[idx] <= sample;
                        if (cnt == LAST) begin
                            cnt <= '0;
                            if (idx == 3'd7) state <= STOP;
                            else             idx   <= idx + 3'd1;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    STOP: begin
                        if (cnt == DEC) begin
                            data_out   <= shift[6:0];
                            parity_err <= ~^shift;
                            frame_err  <= ~sample;
                            valid      <= 1'b1;
                            state      <= IDLE;
                            cnt        <= '0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        cnt   <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_receiver.sv
// tb/tb_receiver.sv - self-checking bench for receiver with a line-level sampling model
module tb_receiver;

    localparam int OS = 16;

    logic       clk    = 1'b0;
    logic       resetN = 1'b0;
    logic       rx_en  = 1'b0;
    logic       rx     = 1'b1;
    logic [6:0] data_out;
    logic       valid;
    logic       parity_err;
    logic       frame_err;
    logic       busy;

    receiver #(.OVERSAMPLE(OS)) dut (
        .clk        (clk),
        .resetN     (resetN),
        .rx_en      (rx_en),
        .rx         (rx),
        .data_out   (data_out),
        .valid      (valid),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [6:0] d;
        logic       pe;
        logic       fe;
    } res_t;

    int   n_checks  = 0;
    int   n_fail    = 0;
    int   tick_div  = 1;
    int   div_cnt   = 0;
    int   busy_clks = 0;
    res_t got_q[$];

    logic [6:0] exp_d  = 7'd0;
    logic       exp_pe = 1'b0;
    logic       exp_fe = 1'b0;

    // oversampling tick generator: one-clk pulse every tick_div clocks
    initial begin
        forever begin
            @(negedge clk);
            if (div_cnt >= tick_div - 1) begin
                div_cnt = 0;
                rx_en   = 1'b1;
            end else begin
                div_cnt = div_cnt + 1;
                rx_en   = 1'b0;
            end
        end
    end

    // record every clock of valid and busy, sampled away from the active edge
    always @(negedge clk) begin
        if (valid) got_q.push_back(res_t'({data_out, parity_err, frame_err}));
        if (busy) busy_clks = busy_clks + 1;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic slot(input logic v);
        @(negedge clk);
        rx = v;
        do @(posedge clk); while (!rx_en);
    endtask

    task automatic idle(input int n, input logic v);
        for (int i = 0; i < n; i++) slot(v);
    endtask

    // builds a 10-bit line image, predicts what mid-bit sampling recovers, drives nslots ticks
    task automatic send_frame(input logic [6:0] d, input logic par, input logic stp,
                              input int glitch, input int nslots,
                              output logic ev, output logic [6:0] ed,
                              output logic epe, output logic efe);
        logic [9:0] bits;
        logic [9:0] smp;
        logic       ln [0:10*OS-1];
        bits = {stp, par, d, 1'b0};
        for (int s = 0; s < 10*OS; s++) ln[s] = bits[s/OS] ^ (s == glitch);
        for (int k = 0; k < 10; k++) begin
`ifdef RX_MAJORITY_EN
            int b;
            b = OS*k + OS/2;
            smp[k] = (ln[b] & ln[b+1]) | (ln[b] & ln[b+2]) | (ln[b+1] & ln[b+2]);
`else
            smp[k] = ln[OS*k + OS/2 + 1];
`endif
        end
        ev  = ~smp[0];
        ed  = smp[7:1];
        epe = ~^smp[8:1];
        efe = ~smp[9];
        for (int s = 0; s < nslots; s++) slot(ln[s]);
    endtask

    task automatic take(output int n, output res_t r);
        n = got_q.size();
        r = '0;
        if (n > 0) r = got_q.pop_front();
        got_q.delete();
    endtask

    task automatic test_reset;
        repeat (4) @(posedge clk);
        @(negedge clk);
        n_checks++; if (data_out !== 7'd0) begin n_fail++; $display("FAIL reset_data_out got %h want 00", data_out); end
        n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", valid); end
        n_checks++; if (parity_err !== 1'b0) begin n_fail++; $display("FAIL reset_parity_err got %b want 0", parity_err); end
        n_checks++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_frame_err got %b want 0", frame_err); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
        resetN = 1'b1;
        idle(20, 1'b1);
        got_q.delete();
    endtask

    task automatic test_basic;
        int n; res_t r; int b0;
        logic ev, epe, efe; logic [6:0] ed;
        b0 = busy_clks;
        send_frame(7'h41, 1'b1, 1'b1, -1, 10*OS, ev, ed, epe, efe);
        idle(16, 1'b1);
        @(negedge clk);
        take(n, r);
        exp_d = ed; exp_pe = epe; exp_fe = efe;
        n_checks++; if (n !== 1) begin n_fail++; $display("FAIL basic_valid_clks got %0d want 1", n); end
        n_checks++; if (r.d !== ed) begin n_fail++; $display("FAIL basic_data got %h want %h", r.d, ed); end
        n_checks++; if (r.pe !== epe) begin n_fail++; $display("FAIL basic_parity_err got %b want %b", r.pe, epe); end
        n_checks++; if (r.fe !== efe) begin n_fail++; $display("FAIL basic_frame_err got %b want %b", r.fe, efe); end
        n_checks++; if (busy_clks - b0 < 9*OS) begin n_fail++; $display("FAIL basic_busy_span got %0d want >= %0d", busy_clks - b0, 9*OS); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy_after got %b want 0", busy); end
    endtask

    task automatic test_parity;
        int n; res_t r;
        logic ev, epe, efe; logic [6:0] ed;
        logic [6:0] dv [2] = '{7'h7F, 7'h00};
        for (int i = 0; i < 2; i++) begin
            send_frame(dv[i], 1'b1, 1'b1, -1, 10*OS, ev, ed, epe, efe);
            idle(16, 1'b1);
            @(negedge clk);
            take(n, r);
            exp_d = ed; exp_pe = epe; exp_fe = efe;
            n_checks++; if (n !== 1) begin n_fail++; $display("FAIL parity_valid_clks[%0d] got %0d want 1", i, n); end
            n_checks++; if (r.d !== ed) begin n_fail++; $display("FAIL parity_data[%0d] got %h want %h", i, r.d, ed); end
            n_checks++; if (r.pe !== epe) begin n_fail++; $display("FAIL parity_err[%0d] got %b want %b", i, r.pe, epe); end
            n_checks++; if (r.fe !== efe) begin n_fail++; $display("FAIL parity_frame_err[%0d] got %b want %b", i, r.fe, efe); end
        end
    endtask

    task automatic test_frame_err;
        int n; res_t r; int b0;
        logic ev, epe, efe; logic [6:0] ed;
        send_frame(7'h2A, 1'b0, 1'b0, -1, 10*OS, ev, ed, epe, efe);
        @(negedge clk);
        b0 = busy_clks;
        idle(40*OS, 1'b0);
        @(negedge clk);
        take(n, r);
        n_checks++; if (n !== 1) begin n_fail++; $display("FAIL ferr_valid_clks got %0d want 1", n); end
        n_checks++; if (r.d !== ed) begin n_fail++; $display("FAIL ferr_data got %h want %h", r.d, ed); end
        n_checks++; if (r.fe !== efe) begin n_fail++; $display("FAIL ferr_flag got %b want %b", r.fe, efe); end
        n_checks++; if (busy_clks !== b0) begin n_fail++; $display("FAIL ferr_busy_while_low got %0d clks want 0", busy_clks - b0); end
        idle(16, 1'b1);
        send_frame(7'h15, 1'b0, 1'b1, -1, 10*OS, ev, ed, epe, efe);
        idle(16, 1'b1);
        @(negedge clk);
        take(n, r);
        exp_d = ed; exp_pe = epe; exp_fe = efe;
        n_checks++; if (n !== 1) begin n_fail++; $display("FAIL ferr_next_valid_clks got %0d want 1", n); end
        n_checks++; if (r.d !== ed) begin n_fail++; $display("FAIL ferr_next_data got %h want %h", r.d, ed); end
        n_checks++; if (r.fe !== efe) begin n_fail++; $display("FAIL ferr_next_flag got %b want %b", r.fe, efe); end
        n_checks++; if (r.pe !== epe) begin n_fail++; $display("FAIL ferr_next_parity got %b want %b", r.pe, epe); end
    endtask

    task automatic test_false_start;
        int n; res_t r; int b0;
        b0 = busy_clks;
        idle(4, 1'b0);
        idle(28, 1'b1);
        @(negedge clk);
        take(n, r);
        n_checks++; if (busy_clks == b0) begin n_fail++; $display("FAIL false_start_busy_seen got 0 clks want >0"); end
        n_checks++; if (n !== 0) begin n_fail++; $display("FAIL false_start_valid got %0d want 0", n); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL false_start_busy_end got %b want 0", busy); end
        n_checks++; if (data_out !== exp_d) begin n_fail++; $display("FAIL false_start_data got %h want %h", data_out, exp_d); end
        n_checks++; if (parity_err !== exp_pe) begin n_fail++; $display("FAIL false_start_parity got %b want %b", parity_err, exp_pe); end
        n_checks++; if (frame_err !== exp_fe) begin n_fail++; $display("FAIL false_start_frame got %b want %b", frame_err, exp_fe); end
    endtask

    task automatic test_reset_mid;
        int n; res_t r;
        logic ev, epe, efe; logic [6:0] ed;
        send_frame(7'h41, 1'b1, 1'b1, -1, 5*OS + 6, ev, ed, epe, efe);
        @(negedge clk);
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rstmid_busy_before got %b want 1", busy); end
        resetN = 1'b0;
        #1;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy got %b want 0", busy); end
        n_checks++; if (data_out !== 7'd0) begin n_fail++; $display("FAIL rstmid_data got %h want 00", data_out); end
        n_checks++; if ({valid, parity_err, frame_err} !== 3'b000) begin n_fail++; $display("FAIL rstmid_flags got %b want 000", {valid, parity_err, frame_err}); end
        @(negedge clk);
        resetN = 1'b1;
        rx = 1'b1;
        idle(16, 1'b1);
        send_frame(7'h55, 1'b1, 1'b1, -1, 10*OS, ev, ed, epe, efe);
        idle(16, 1'b1);
        @(negedge clk);
        take(n, r);
        exp_d = ed; exp_pe = epe; exp_fe = efe;
        n_checks++; if (n !== 1) begin n_fail++; $display("FAIL rstmid_next_valid got %0d want 1", n); end
        n_checks++; if (r.d !== ed) begin n_fail++; $display("FAIL rstmid_next_data got %h want %h", r.d, ed); end
        n_checks++; if ({r.pe, r.fe} !== {epe, efe}) begin n_fail++; $display("FAIL rstmid_next_flags got %b want %b", {r.pe, r.fe}, {epe, efe}); end
    endtask

    task automatic test_glitch;
        int n; res_t r;
        logic ev, epe, efe; logic [6:0] ed;
        tick_div = 3;
        idle(4, 1'b1);
        send_frame(7'h41, 1'b1, 1'b1, 3*OS + OS/2 + 1, 10*OS, ev, ed, epe, efe);
        idle(16, 1'b1);
        @(negedge clk);
        take(n, r);
        exp_d = ed; exp_pe = epe; exp_fe = efe;
        n_checks++; if (n !== 1) begin n_fail++; $display("FAIL glitch_valid_clks got %0d want 1", n); end
        n_checks++; if (r.d !== ed) begin n_fail++; $display("FAIL glitch_data got %h want %h", r.d, ed); end
        n_checks++; if (r.pe !== epe) begin n_fail++; $display("FAIL glitch_parity got %b want %b", r.pe, epe); end
        n_checks++; if (r.fe !== efe) begin n_fail++; $display("FAIL glitch_frame got %b want %b", r.fe, efe); end
        tick_div = 1;
    endtask

    task automatic test_back_to_back;
        logic [6:0] ed [3];
        logic       epe [3];
        logic       efe [3];
        logic       ev;
        logic [6:0] d;
        res_t       r;
        tick_div = int'($urandom_range(1, 3));
        idle(4, 1'b1);
        for (int i = 0; i < 3; i++) begin
            d = 7'($urandom);
            send_frame(d, ~^d, 1'b1, -1, 10*OS, ev, ed[i], epe[i], efe[i]);
        end
        idle(16, 1'b1);
        @(negedge clk);
        n_checks++; if (got_q.size() !== 3) begin n_fail++; $display("FAIL b2b_count got %0d want 3", got_q.size()); end
        for (int i = 0; i < 3; i++) begin
            r = (got_q.size() > 0) ? got_q.pop_front() : res_t'('0);
            n_checks++; if ({r.d, r.pe, r.fe} !== {ed[i], epe[i], efe[i]}) begin n_fail++; $display("FAIL b2b_frame[%0d] got %h/%b/%b want %h/%b/%b", i, r.d, r.pe, r.fe, ed[i], epe[i], efe[i]); end
        end
        got_q.delete();
        exp_d = ed[2]; exp_pe = epe[2]; exp_fe = efe[2];
        tick_div = 1;
    endtask

    task automatic test_random;
        int n; res_t r;
        logic ev, epe, efe; logic [6:0] ed;
        logic [6:0] d; logic p; logic s;
        for (int i = 0; i < 6; i++) begin
            tick_div = int'($urandom_range(1, 3));
            d = 7'($urandom);
            p = 1'($urandom);
            s = 1'($urandom);
            send_frame(d, p, s, -1, 10*OS, ev, ed, epe, efe);
            idle(20, 1'b1);
            @(negedge clk);
            take(n, r);
            n_checks++; if (n !== 1) begin n_fail++; $display("FAIL random_valid[%0d] got %0d want 1", i, n); end
            n_checks++; if ({r.d, r.pe, r.fe} !== {ed, epe, efe}) begin n_fail++; $display("FAIL random_frame[%0d] got %h/%b/%b want %h/%b/%b", i, r.d, r.pe, r.fe, ed, epe, efe); end
        end
        tick_div = 1;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_parity();
        test_frame_err();
        test_false_start();
        test_reset_mid();
        test_glitch();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/receiver.md
Name: receiver

Overview:
UART serial receiver, the counterpart of the team's transmitter. It recovers frames of 1 start bit (0), 7 data bits LSB-first, 1 odd-parity bit and 1 stop bit (1) from the serial line. Bit timing comes from an external oversampling tick `rx_en`, pulsed at OVERSAMPLE x the bit rate by the shared baud generator. It presents the 7-bit word with a one-clock valid strobe plus parity and framing error flags.

Parameters:
- OVERSAMPLE, 16: rx_en ticks per bit period; must be even and >= 4. The tick counter is $clog2(OVERSAMPLE) bits wide.

Ports:
- clk  input  1  system clock; all state updates on rising edge
- resetN  input  1  asynchronous active-low reset
- rx_en  input  1  oversampling tick; one-clk pulse, OVERSAMPLE per bit
- rx  input  1  serial line, asynchronous to clk; idle high
- data_out  output  7  last received word, held until the next frame completes
- valid  output  1  one-clk strobe: new data_out and error flags are available
- parity_err  output  1  last frame's 8 received bits had an even count of ones; held
- frame_err  output  1  last frame's stop bit was sampled 0; held
- busy  output  1  high while state != IDLE

Behaviour:
- Clock/reset: one clock; reset asynchronous active-low on resetN.
- Reset values:
  - data_out=0, valid=0, parity_err=0, frame_err=0, busy=0.
  - State=IDLE, tick counter=0, bit index=0, shift register=0, armed=0.
  - Both synchronizer flops =1.
- Input path: rx passes through a 2-flop synchronizer to give rx_s (2 clk latency). All decisions use rx_s and happen only on clk edges where rx_en=1.
- Sample point per bit:
  - Decision tick is count==OVERSAMPLE/2; sampled value = rx_s on that tick.
  - The counter runs 0..OVERSAMPLE-1 per bit, then wraps to 0 and the bit index advances.
- IDLE:
  - On a tick with rx_s=1, set armed=1.
  - On a tick with rx_s=0 and armed=1, go to START with counter=0 and armed=0.
  - A line held low never re-triggers the receiver.
- START: at the decision tick:
  - If sampled 1: false start; return to IDLE (no valid, no flag change).
  - If sampled 0: continue; at count OVERSAMPLE-1 go to DATA, bit index=0.
- DATA:
  - At the decision tick, store the sampled bit at shift[index]. Bits 0..6 are data; index 7 is parity.
  - At count OVERSAMPLE-1 with index 7, go to STOP; otherwise index+1.
- STOP: at the decision tick, in one update:
  - data_out<=shift[6:0]
  - parity_err<=~^shift[7:0] (error when the total count of ones is even)
  - frame_err<=~sample
  - valid<=1 for exactly that one clk
  - go to IDLE
- Returning at mid-stop allows back-to-back frames with a one-bit stop. After a frame error the line must return high (re-arm) before the next start is accepted.
- valid latency: valid is high in the clk following the STOP decision tick. data_out and the flags are updated in that same clk.
- Simultaneous events: an rx_en tick on the same edge as resetN falling is ignored (reset wins). rx_en high for consecutive clocks counts as consecutive ticks.
- Reset mid-frame: the partial frame is discarded and all outputs return to reset values immediately. The next frame needs armed, i.e. at least one idle-high tick after reset.

Optional Feature:
- RX_MAJORITY_EN
- Defined: the sampled value is the majority of rx_s on ticks OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1. The decision (start check, shift, stop/valid) is taken at tick OVERSAMPLE/2+1, so valid moves one tick later.
- Undefined: single sample at OVERSAMPLE/2, and no vote registers exist.

Test Plan:
- Reset, idle rx=1, rx_en every clk, OVERSAMPLE=16. Send 7'h41 with parity bit 1 and stop 1 (line sequence 0,1,0,0,0,0,0,1,1,1, 16 ticks each) -> one valid pulse, data_out=7'h41, parity_err=0, frame_err=0, busy 1->0 after the stop decision.
- Send 7'h7F with a wrong parity bit 1 -> valid, data_out=7'h7F, parity_err=1, frame_err=0. Then send 7'h00 with parity 1 -> parity_err=0.
- Send 7'h2A with stop bit 0, then hold rx=0 for 40 bit times -> valid, frame_err=1, no further valid or busy while low. Release high, then send 7'h15 -> data_out=7'h15, frame_err=0.
- Idle rx glitch low for 4 ticks -> START entered, rejected at tick 8, no valid, busy returns to 0, flags unchanged.
- Assert resetN=0 while in DATA at bit index 4 -> outputs 0 and busy=0 immediately. Release, then send 7'h55 with parity 1 -> data_out=7'h55, no errors.
- rx_en every 3 clks, one-tick rx inversion on tick 8 of data bit 2 of 7'h41 -> with RX_MAJORITY_EN, data_out=7'h41; without it, data_out=7'h45 and parity_err=1.
